// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared IF-stage types, constants and PC alignment helper
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INC      = 2'd1,
        PC_TARGET   = 2'd2,
        PC_REDIRECT = 2'd3
    } pc_sel_t;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with next-PC select and target alignment
module fetch_pc_reg
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  pc_sel_t     pc_sel,
    input  logic [31:0] branch_target,
    input  logic [31:0] redirect,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_next;

    // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0.
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        pc_next = pc;
        case (pc_sel)
            PC_HOLD:     pc_next = pc;
            PC_INC:      pc_next = pc_plus4;
            PC_TARGET:   pc_next = align_word(branch_target);
            PC_REDIRECT: pc_next = align_word(redirect);
            default:     pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= align_word(RESET_PC);
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - MIPS IF stage: PC, imem handshake, flush/stall; FETCH_PERF_CNT_EN adds perf counters
module instr_fetch_stage
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF,
    parameter int          PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pc_write,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_target,
    output logic                  imem_req,
    output logic [31:0]           imem_addr,
    input  logic                  imem_ready,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           if_pc_plus4,
    output logic [31:0]           if_instruction,
    output logic                  if_id_write
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_fetch_cnt,
    output logic [PERF_CNT_W-1:0] perf_bubble_cnt
`endif
);

    fetch_state_t state, state_n;
    pc_sel_t      pc_sel;
    logic [31:0]  pc, pc_plus4;
    logic [31:0]  hold_buf, redirect;
    logic         hold_load, redirect_load;
    logic         req_raw;
    logic         deliver_valid;
    logic [31:0]  deliver_data;

    fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .reset        (reset),
        .pc_sel       (pc_sel),
        .branch_target(branch_target),
        .redirect     (redirect),
        .pc           (pc),
        .pc_plus4     (pc_plus4)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            hold_buf <= 32'h0;
            redirect <= 32'h0;
        end else begin
            state <= state_n;
            if (hold_load) begin
                hold_buf <= imem_rdata;
            end
            if (redirect_load) begin
                redirect <= align_word(branch_target);
            end
        end
    end

    always_comb begin
        state_n       = state;
        pc_sel        = PC_HOLD;
        hold_load     = 1'b0;
        redirect_load = 1'b0;
        req_raw       = 1'b0;
        deliver_valid = 1'b0;
        deliver_data  = NOP_INSTR;
        case (state)
            S_FETCH: begin
                req_raw = 1'b1;
                if (imem_ready) begin
                    if (branch_taken) begin
                        pc_sel = PC_TARGET;
                    end else if (pc_write) begin
                        deliver_valid = 1'b1;
                        deliver_data  = imem_rdata;
                        pc_sel        = PC_INC;
                    end else begin
                        hold_load = 1'b1;
                        state_n   = S_HOLD;
                    end
                end else if (branch_taken) begin
                    // The bus cannot cancel a request, so wait it out before redirecting.
                    redirect_load = 1'b1;
                    state_n       = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    pc_sel  = PC_TARGET;
                    state_n = S_FETCH;
                end else if (pc_write) begin
                    deliver_valid = 1'b1;
                    deliver_data  = hold_buf;
                    pc_sel        = PC_INC;
                    state_n       = S_FETCH;
                end
            end
            S_DRAIN: begin
                req_raw = 1'b1;
                if (branch_taken) begin
                    redirect_load = 1'b1;
                end
                if (imem_ready) begin
                    // A branch landing on the completing cycle is the newest redirect.
                    pc_sel  = branch_taken ? PC_TARGET : PC_REDIRECT;
                    state_n = S_FETCH;
                end
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    assign imem_req       = !reset && req_raw;
    assign imem_addr      = reset ? 32'h0 : pc;
    assign if_pc_plus4    = reset ? 32'h0 : pc_plus4;
    assign if_id_write    = !reset && (pc_write || branch_taken);
    assign if_instruction = reset ? 32'h0 : (deliver_valid ? deliver_data : NOP_INSTR);

`ifdef FETCH_PERF_CNT_EN
    logic perf_fetch_inc, perf_bubble_inc;

    assign perf_fetch_inc  = if_id_write && deliver_valid;
    assign perf_bubble_inc = if_id_write && !deliver_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (perf_fetch_inc && (perf_fetch_cnt != '1)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
            end
            if (perf_bubble_inc && (perf_bubble_cnt != '1)) begin
                perf_bubble_cnt <= perf_bubble_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
